tdc_ro_meas_sequencer: RTL and testbench

//  Measurement sequencer for the micro-tile sensor fabric: launches a TDC start edge and captures the 8-bit

---
 rtl/tdc_ro_meas_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_tdc_ro_meas_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_ro_meas_sequencer.sv
// Sensor measurement sequencer: one TDC capture or one gated RO edge count per stage,
// with mode 2'b11 chaining TDC -> RO1 -> RO2; results leave on a valid/ready port.
module tdc_ro_meas_sequencer #(
   parameter int SETTLE_CYCLES = 4,
   parameter int WIN_CYCLES    = 256,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [1:0]       mode_i,
   output logic             busy_o,
   output logic             tdc_start_o,
   input  logic [7:0]       tdc_code_i,
   output logic [1:0]       ro_en_o,
   input  logic [1:0]       ro_tap_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [1:0]       res_tag_o,
   output logic [CNT_W-1:0] res_data_o,
   output logic             res_sat_o
);

   localparam int TMR_MAX = (SETTLE_CYCLES > WIN_CYCLES) ? SETTLE_CYCLES : WIN_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {IDLE, TDC_LAUNCH, TDC_SETTLE, RO_WARM, RO_COUNT, OUT} state_t;

   state_t           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic             busy_q, busy_d;
   logic             tdc_start_q, tdc_start_d;
   logic [1:0]       ro_en_q, ro_en_d;
   logic             ro_sel_q, ro_sel_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [2:0]       sync_q, sync_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;
   logic             res_valid_q, res_valid_d;
   logic [1:0]       res_tag_q, res_tag_d;
   logic [CNT_W-1:0] res_data_q, res_data_d;
   logic             res_sat_q, res_sat_d;

   logic             tap_sel, ro_edge, ro_go, ro_go_sel;
   logic [CNT_W-1:0] cnt_nxt;
   logic             sat_nxt;

   function automatic logic [3:0] popcnt8(input logic [7:0] v);
      logic [3:0] s;
      s = '0;
      for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
      return s;
   endfunction

   assign tap_sel = ro_sel_q ? ro_tap_i[1] : ro_tap_i[0];
   assign ro_edge = sync_q[1] & ~sync_q[2];

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      busy_d      = busy_q;
      tdc_start_d = 1'b0;
      ro_en_d     = ro_en_q;
      ro_sel_d    = ro_sel_q;
      tmr_d       = tmr_q;
      sync_d      = sync_q;
      cnt_d       = cnt_q;
      sat_d       = sat_q;
      res_valid_d = res_valid_q;
      res_tag_d   = res_tag_q;
      res_data_d  = res_data_q;
      res_sat_d   = res_sat_q;
      ro_go       = 1'b0;
      ro_go_sel   = 1'b0;

      // sat marks an edge that arrived while the counter was already pinned at max
      cnt_nxt = cnt_q;
      sat_nxt = sat_q;
      if (ro_edge) begin
         if (cnt_q == CNT_MAX) sat_nxt = 1'b1;
         else                  cnt_nxt = cnt_q + CNT_W'(1);
      end

      case (state_q)
         IDLE: if (start_i) begin
            mode_d = mode_i;
            busy_d = 1'b1;
            case (mode_i)
               2'b01:   ro_go = 1'b1;
               2'b10:   begin ro_go = 1'b1; ro_go_sel = 1'b1; end
               default: begin state_d = TDC_LAUNCH; tdc_start_d = 1'b1; end
            endcase
         end
         TDC_LAUNCH: begin
            state_d = TDC_SETTLE;
            tmr_d   = TMR_W'(SETTLE_CYCLES - 1);
         end
         TDC_SETTLE: begin
            if (tmr_q == '0) begin
               state_d     = OUT;
               res_valid_d = 1'b1;
               res_tag_d   = 2'b00;
               res_data_d  = CNT_W'(popcnt8(tdc_code_i));
               res_sat_d   = 1'b0;
            end else tmr_d = tmr_q - TMR_W'(1);
         end
         RO_WARM: begin
            sync_d = {sync_q[1:0], tap_sel};
            if (tmr_q == '0) begin
               state_d = RO_COUNT;
               tmr_d   = TMR_W'(WIN_CYCLES - 1);
            end else tmr_d = tmr_q - TMR_W'(1);
         end
         RO_COUNT: begin
            sync_d = {sync_q[1:0], tap_sel};
            cnt_d  = cnt_nxt;
            sat_d  = sat_nxt;
            if (tmr_q == '0) begin
               state_d     = OUT;
               ro_en_d     = 2'b00;
               res_valid_d = 1'b1;
               res_tag_d   = ro_sel_q ? 2'b10 : 2'b01;
               res_data_d  = cnt_nxt;
               res_sat_d   = sat_nxt;
            end else tmr_d = tmr_q - TMR_W'(1);
         end
         OUT: if (res_ready_i) begin
            res_valid_d = 1'b0;
            if (mode_q == 2'b11 && res_tag_q == 2'b00) ro_go = 1'b1;
            else if (mode_q == 2'b11 && res_tag_q == 2'b01) begin
               ro_go     = 1'b1;
               ro_go_sel = 1'b1;
            end else begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (ro_go) begin
         state_d  = RO_WARM;
         ro_sel_d = ro_go_sel;
         ro_en_d  = ro_go_sel ? 2'b10 : 2'b01;
         tmr_d    = TMR_W'(1);
         sync_d   = '0;
         cnt_d    = '0;
         sat_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mode_q      <= '0;
         busy_q      <= 1'b0;
         tdc_start_q <= 1'b0;
         ro_en_q     <= '0;
         ro_sel_q    <= 1'b0;
         tmr_q       <= '0;
         sync_q      <= '0;
         cnt_q       <= '0;
         sat_q       <= 1'b0;
         res_valid_q <= 1'b0;
         res_tag_q   <= '0;
         res_data_q  <= '0;
         res_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         busy_q      <= busy_d;
         tdc_start_q <= tdc_start_d;
         ro_en_q     <= ro_en_d;
         ro_sel_q    <= ro_sel_d;
         tmr_q       <= tmr_d;
         sync_q      <= sync_d;
         cnt_q       <= cnt_d;
         sat_q       <= sat_d;
         res_valid_q <= res_valid_d;
         res_tag_q   <= res_tag_d;
         res_data_q  <= res_data_d;
         res_sat_q   <= res_sat_d;
      end
   end

   assign busy_o      = busy_q;
   assign tdc_start_o = tdc_start_q;
   assign ro_en_o     = ro_en_q;
   assign res_valid_o = res_valid_q;
   assign res_tag_o   = res_tag_q;
   assign res_data_o  = res_data_q;
   assign res_sat_o   = res_sat_q;

endmodule

// File: tb/tb_tdc_ro_meas_sequencer.sv
// Bench for tdc_ro_meas_sequencer: vector table plus scoreboard of expected results,
// and hand sequences for timing, stalls, mid-run reset and saturation.
module tb_tdc_ro_meas_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, start4;
   logic [1:0]  mode;
   logic [7:0]  code;
   logic [1:0]  ro_tap;
   logic        ready, ready4;
   logic        busy, tdc_start, res_valid, res_sat;
   logic [1:0]  ro_en, res_tag;
   logic [15:0] res_data;
   logic        busy4, tdc_start4, res_valid4, res_sat4;
   logic [1:0]  ro_en4, res_tag4;
   logic [3:0]  res_data4;

   always #5 clk = ~clk;

   tdc_ro_meas_sequencer dut (
      .clk(clk), .rst(rst), .start_i(start), .mode_i(mode), .busy_o(busy),
      .tdc_start_o(tdc_start), .tdc_code_i(code), .ro_en_o(ro_en), .ro_tap_i(ro_tap),
      .res_valid_o(res_valid), .res_ready_i(ready), .res_tag_o(res_tag),
      .res_data_o(res_data), .res_sat_o(res_sat));

   tdc_ro_meas_sequencer #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .start_i(start4), .mode_i(mode), .busy_o(busy4),
      .tdc_start_o(tdc_start4), .tdc_code_i(code), .ro_en_o(ro_en4), .ro_tap_i(ro_tap),
      .res_valid_o(res_valid4), .res_ready_i(ready4), .res_tag_o(res_tag4),
      .res_data_o(res_data4), .res_sat_o(res_sat4));

   typedef struct {
      logic [1:0]  tag;
      logic [15:0] data;
      int          tol;
      logic        sat;
   } exp_t;

   typedef struct {
      logic [1:0] mode;
      logic [7:0] code;
      int         tap_period;
      exp_t       exp;
   } vec_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ring-oscillator tap model: square wave with a period in clk cycles (0 = held low)
   int tap_period = 0;
   int tap_ph = 0;
   always @(negedge clk) begin
      if (tap_period == 0) begin
         tap_ph = 0;
         ro_tap = 2'b00;
      end else begin
         tap_ph = (tap_ph + 1) % tap_period;
         ro_tap = {2{tap_ph < tap_period / 2}};
      end
   end

   // scoreboard monitor and hold-stability checker, sampled on the falling edge
   exp_t        mon_e;
   int          mon_diff;
   logic        hold_vld = 1'b0;
   logic [18:0] hold_val;
   always @(negedge clk) begin
      if (rst) hold_vld = 1'b0;
      else if (res_valid) begin
         if (hold_vld) chk("stall_stable", {13'd0, hold_val}, {13'd0, res_tag, res_sat, res_data});
         hold_val = {res_tag, res_sat, res_data};
         hold_vld = !ready;
         if (ready) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got tag %0d data %0d expected none", res_tag, res_data);
            end else begin
               mon_e = sbq.pop_front();
               chk("res_tag", {30'd0, res_tag}, {30'd0, mon_e.tag});
               chk("res_sat", {31'd0, res_sat}, {31'd0, mon_e.sat});
               mon_diff = int'(res_data) - int'(mon_e.data);
               checks++;
               if (mon_diff > mon_e.tol || mon_diff < -mon_e.tol) begin
                  errors++;
                  $display("FAIL res_data: got %0d expected %0d +/-%0d", res_data, mon_e.data, mon_e.tol);
               end
            end
         end
      end else hold_vld = 1'b0;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin step(1); n++; end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
      end
   endtask

   task automatic wait_valid(input int budget);
      int n = 0;
      while (!res_valid && n < budget) begin step(1); n++; end
      if (!res_valid) begin
         checks++;
         errors++;
         $display("FAIL valid_timeout: got no valid after %0d cycles expected valid", n);
      end
   endtask

   // start_i sampled at the next edge k; returns in cycle k+1
   task automatic run(input logic [1:0] m);
      mode  = m;
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{2'b00, 8'h1F,        0, '{2'b00, 16'd5,  0, 1'b0}};
      vecs[1] = '{2'b00, 8'h00,        0, '{2'b00, 16'd0,  0, 1'b0}};
      vecs[2] = '{2'b00, 8'hFF,        0, '{2'b00, 16'd8,  0, 1'b0}};
      vecs[3] = '{2'b00, 8'b0101_0011, 0, '{2'b00, 16'd4,  0, 1'b0}};
      vecs[4] = '{2'b01, 8'h00,        8, '{2'b01, 16'd32, 1, 1'b0}};
      vecs[5] = '{2'b10, 8'h00,       16, '{2'b10, 16'd16, 1, 1'b0}};
      vecs[6] = '{2'b10, 8'h00,        0, '{2'b10, 16'd0,  0, 1'b0}};

      rst = 1'b1; start = 1'b0; start4 = 1'b0; mode = 2'b00; code = 8'h00;
      ready = 1'b1; ready4 = 1'b1;
      #1;
      chk("reset_outputs", {6'd0, busy, tdc_start, ro_en, res_valid, res_tag, res_sat, res_data},
          32'd0);
      step(2);
      rst = 1'b0;
      step(1);

      // TDC launch/capture timing
      code = 8'b0001_1111;
      sbq.push_back('{2'b00, 16'd5, 0, 1'b0});
      run(2'b00);
      chk("tdc_start_k1", {30'd0, busy, tdc_start}, 32'd3);
      step(1);
      chk("tdc_start_k2", {31'd0, tdc_start}, 32'd0);
      step(3);
      chk("valid_k5", {31'd0, res_valid}, 32'd0);
      step(1);
      chk("valid_k6", {31'd0, res_valid}, 32'd1);
      step(1);
      chk("after_xfer", {30'd0, busy, res_valid}, 32'd0);
      chk("data_kept", {16'd0, res_data}, 32'd5);

      // vector table
      foreach (vecs[i]) begin
         code       = vecs[i].code;
         tap_period = vecs[i].tap_period;
         sbq.push_back(vecs[i].exp);
         run(vecs[i].mode);
         wait_idle(600);
         chk("sb_drained", sbq.size(), 32'd0);
      end

      // RO1 enable window length
      begin
         int n = 0;
         tap_period = 8;
         sbq.push_back('{2'b01, 16'd32, 1, 1'b0});
         run(2'b01);
         while (ro_en == 2'b01 && n < 400) begin step(1); n++; end
         chk("ro_en_cycles", n, 32'd258);
         chk("ro_valid_at_drop", {29'd0, ro_en, res_valid}, 32'd1);
         wait_idle(50);
      end

      // reset in the middle of a count window
      run(2'b01);
      step(100);
      #2;
      rst = 1'b1;
      #1;
      chk("midrun_reset", {27'd0, ro_en, busy, res_valid, tdc_start}, 32'd0);
      step(1);
      rst = 1'b0;
      step(3);
      chk("no_restart", {31'd0, busy}, 32'd0);
      code = 8'h03;
      sbq.push_back('{2'b00, 16'd2, 0, 1'b0});
      run(2'b00);
      wait_idle(50);
      chk("after_reset_drained", sbq.size(), 32'd0);

      // chained mode with consumer stalls
      ready = 1'b0;
      code  = 8'h07;
      tap_period = 8;
      sbq.push_back('{2'b00, 16'd3,  0, 1'b0});
      sbq.push_back('{2'b01, 16'd32, 1, 1'b0});
      sbq.push_back('{2'b10, 16'd32, 1, 1'b0});
      run(2'b11);
      for (int r = 0; r < 3; r++) begin
         wait_valid(400);
         step(10);
         chk("chain_ro_en_out", {30'd0, ro_en}, 32'd0);
         ready = 1'b1;
         step(1);
         ready = 1'b0;
         chk("chain_valid_drop", {31'd0, res_valid}, 32'd0);
      end
      chk("chain_busy_end", {31'd0, busy}, 32'd0);
      chk("chain_drained", sbq.size(), 32'd0);
      ready = 1'b1;

      // start and mode activity while busy are ignored
      sbq.push_back('{2'b01, 16'd32, 1, 1'b0});
      run(2'b01);
      for (int c = 0; c < 50; c++) begin
         start = c[0];
         mode  = 2'(c);
         step(1);
      end
      start = 1'b0;
      wait_idle(400);
      step(5);
      chk("busy_ignore_idle", {31'd0, busy}, 32'd0);
      chk("busy_ignore_drained", sbq.size(), 32'd0);

      // saturation with a 4-bit counter
      tap_period = 4;
      mode   = 2'b01;
      start4 = 1'b1;
      step(1);
      start4 = 1'b0;
      begin
         int n = 0;
         while (!res_valid4 && n < 400) begin step(1); n++; end
         chk("sat4_valid", {31'd0, res_valid4}, 32'd1);
      end
      chk("sat4_data", {28'd0, res_data4}, 32'd15);
      chk("sat4_sat", {31'd0, res_sat4}, 32'd1);
      chk("sat4_tag", {30'd0, res_tag4}, 32'd1);
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
